// File: rtl/digit_line_sequencer.sv
// rtl/digit_line_sequencer.sv - glyph row fetch and pixel serialiser for digit text cells
//
// Purpose: during horizontal blanking, fetches one glyph row per text cell from
// the registered 64-entry digit ROM into a fetch buffer. On inCellStart, swaps
// that buffer into a display buffer and serialises it MSB-first, with CELL_GAP
// blank pixels after each cell.
//
// Optional feature macro: DIGIT_SEQ_INVERT_EN (adds per-cell inInvert input).
//
// Ports:
//   pixelClk      in   pixel clock, all state on rising edge
//   reset         in   asynchronous active-high reset
//   inLineStart   in   pulse: fetch rows for the upcoming line
//   inRowEnable   in   0 = upcoming line is outside the text band
//   inGlyphRow    in   [3:0] glyph row for the upcoming line
//   inCodes       in   [2*NUM_CELLS-1:0] glyph codes, cell 0 in [1:0]
//   inInvert      in   [NUM_CELLS-1:0] per-cell invert (DIGIT_SEQ_INVERT_EN only)
//   inCellStart   in   pulse: start emitting the band next cycle
//   romAddress    out  [5:0] ROM address {code,row}
//   romData       in   [7:0] ROM data, valid the cycle after the address
//   outPixel      out  serialised pixel
//   outPixelValid out  high for the whole band, gap pixels included
//   outBusy       out  fetch in progress
//   outOverrun    out  pulse: inCellStart arrived during a fetch
module digit_line_sequencer #(
   parameter int NUM_CELLS = 4,
   parameter int CELL_GAP  = 0
) (
   input  logic                   pixelClk,
   input  logic                   reset,
   input  logic                   inLineStart,
   input  logic                   inRowEnable,
   input  logic [3:0]             inGlyphRow,
   input  logic [2*NUM_CELLS-1:0] inCodes,
`ifdef DIGIT_SEQ_INVERT_EN
   input  logic [NUM_CELLS-1:0]   inInvert,
`endif
   input  logic                   inCellStart,
   output logic [5:0]             romAddress,
   input  logic [7:0]             romData,
   output logic                   outPixel,
   output logic                   outPixelValid,
   output logic                   outBusy,
   output logic                   outOverrun
);

   localparam int CW       = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;
   localparam int LAST_IDX = NUM_CELLS - 1;
   localparam int PIX      = 8 + CELL_GAP;

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cell_idx_q, cell_idx_d;
   logic [1:0]        codes_q [NUM_CELLS];
   logic [3:0]        row_q;
   logic [5:0]        addr_hold_q;
   logic [7:0]        fbuf_q [NUM_CELLS];
   logic [NUM_CELLS-1:0] fetch_inv_q;
   logic              fetch_valid_q;
   logic [7:0]        disp_q [NUM_CELLS];
   logic [NUM_CELLS-1:0] disp_inv_q;
   logic              active_q;
   logic [CW-1:0]     cell_q;
   logic [3:0]        bit_q;
   logic              overrun_q;

   logic              fetch_start;
   logic              blank_line;
   logic              swap;
   logic [NUM_CELLS-1:0] inv_in;
   logic [2:0]        bit_sel;
   logic              glyph_bit;

`ifdef DIGIT_SEQ_INVERT_EN
   assign inv_in = inInvert;
`else
   assign inv_in = '0;
`endif

   assign outBusy       = (state_q != IDLE);
   assign outPixelValid = active_q;
   assign outOverrun    = overrun_q;
   // A swap only happens between fetches; a mid-fetch start gets a zero band.
   assign swap          = inCellStart && !outBusy;

   // Address is live only while fetching; otherwise the last one is held.
   assign romAddress = (state_q == FETCH) ? {codes_q[cell_idx_q], row_q} : addr_hold_q;

   always_comb begin
      state_d     = state_q;
      cell_idx_d  = cell_idx_q;
      fetch_start = 1'b0;
      blank_line  = 1'b0;
      case (state_q)
         IDLE: begin
            if (inLineStart) begin
               if (inRowEnable) begin
                  state_d     = FETCH;
                  cell_idx_d  = '0;
                  fetch_start = 1'b1;
               end else begin
                  blank_line  = 1'b1;
               end
            end
         end
         FETCH: begin
            cell_idx_d = cell_idx_q + CW'(1);
            if (cell_idx_q == CW'(LAST_IDX)) state_d = DRAIN;
         end
         DRAIN:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Fetch side: ROM data lags the address by one cycle, hence slot cellIdx-1.
   always_ff @(posedge pixelClk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         cell_idx_q    <= '0;
         row_q         <= '0;
         addr_hold_q   <= '0;
         fetch_inv_q   <= '0;
         fetch_valid_q <= 1'b0;
         for (int i = 0; i < NUM_CELLS; i++) begin
            codes_q[i] <= '0;
            fbuf_q[i]  <= '0;
         end
      end else begin
         state_q    <= state_d;
         cell_idx_q <= cell_idx_d;
         if (state_q == FETCH) addr_hold_q <= romAddress;
         // Clear first so a same-cycle blank line still marks the buffer valid.
         if (swap) fetch_valid_q <= 1'b0;
         if (fetch_start) begin
            row_q       <= inGlyphRow;
            fetch_inv_q <= inv_in;
            for (int i = 0; i < NUM_CELLS; i++) codes_q[i] <= inCodes[2*i +: 2];
         end
         if (blank_line) begin
            fetch_valid_q <= 1'b1;
            fetch_inv_q   <= '0;
            for (int i = 0; i < NUM_CELLS; i++) fbuf_q[i] <= '0;
         end
         if (state_q == FETCH && cell_idx_q != '0) fbuf_q[cell_idx_q - CW'(1)] <= romData;
         if (state_q == DRAIN) begin
            fbuf_q[LAST_IDX] <= romData;
            fetch_valid_q    <= 1'b1;
         end
      end
   end

   // Emission side: any inCellStart (re)starts the band at pixel 0.
   always_ff @(posedge pixelClk or posedge reset) begin
      if (reset) begin
         active_q   <= 1'b0;
         cell_q     <= '0;
         bit_q      <= '0;
         overrun_q  <= 1'b0;
         disp_inv_q <= '0;
         for (int i = 0; i < NUM_CELLS; i++) disp_q[i] <= '0;
      end else if (inCellStart) begin
         active_q   <= 1'b1;
         cell_q     <= '0;
         bit_q      <= '0;
         overrun_q  <= outBusy;
         disp_inv_q <= (swap && fetch_valid_q) ? fetch_inv_q : '0;
         for (int i = 0; i < NUM_CELLS; i++)
            disp_q[i] <= (swap && fetch_valid_q) ? fbuf_q[i] : 8'h00;
      end else begin
         overrun_q <= 1'b0;
         if (active_q) begin
            if (bit_q == 4'(PIX - 1)) begin
               bit_q <= '0;
               if (cell_q == CW'(LAST_IDX)) active_q <= 1'b0;
               else                          cell_q   <= cell_q + CW'(1);
            end else begin
               bit_q <= bit_q + 4'd1;
            end
         end
      end
   end

   // Gap pixels (bit_q >= 8) are forced to zero and never inverted.
   always_comb begin
      bit_sel   = 3'd7 - bit_q[2:0];
      glyph_bit = disp_q[cell_q][bit_sel] ^ disp_inv_q[cell_q];
      outPixel  = active_q & (bit_q < 4'd8) & glyph_bit;
   end

endmodule

// File: doc/digit_line_sequencer.md
# digit_line_sequencer

Scanline sequencer for the 64-entry digit glyph ROM: 4 glyphs × 16 rows, address = {code[1:0], row[3:0]}, one registered 8-bit row per read. During horizontal blanking it fetches one glyph row per text cell into a fetch buffer. On the cell-band start pulse it swaps that buffer into a display buffer and serialises pixels MSB-first to the VGA pixel mux. It sits between the sync/timing generator and the glyph ROM, and is the ROM's only master.

## Interface
- NUM_CELLS, 4, number of digit cells per text line (1..8)
- CELL_GAP, 0, blank pixels emitted after each cell (0..7)
- pixelClk  in  1  pixel clock; all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- inLineStart  in  1  single-cycle pulse: fetch rows for the upcoming line
- inRowEnable  in  1  sampled with inLineStart; 0 = upcoming line outside text band
- inGlyphRow  in  4  glyph row for the upcoming line, sampled with inLineStart
- inCodes  in  2*NUM_CELLS  glyph code per cell, sampled with inLineStart; cell 0 in bits [1:0]
- inCellStart  in  1  single-cycle pulse: begin emitting the text band next cycle
- romAddress  out  6  ROM address {code,row}
- romData  in  8  ROM output, valid the cycle after romAddress is presented
- outPixel  out  1  serialised pixel
- outPixelValid  out  1  high while the band is emitted, including gap pixels
- outBusy  out  1  fetch in progress
- outOverrun  out  1  one-cycle pulse: inCellStart arrived while outBusy

## Operation
- Fetch FSM states: IDLE, FETCH, DRAIN.
- IDLE + inLineStart + inRowEnable=1: latch inCodes and inGlyphRow, set cellIdx=0, go to FETCH.
- IDLE + inLineStart + inRowEnable=0: fetch buffer cleared to zero, fetchValid=1, stay in IDLE.
- FETCH: each cycle drive romAddress={code[cellIdx],row}; capture romData into fetch buffer slot cellIdx-1 when cellIdx>0; increment cellIdx; after cellIdx=NUM_CELLS-1, go to DRAIN.
- DRAIN: capture slot NUM_CELLS-1, set fetchValid=1, go to IDLE.
- inLineStart outside IDLE is ignored.
- romAddress holds its last value when not fetching. Reset value is 0.
- Emission counter: on inCellStart with outBusy=0, copy the fetch buffer into the display buffer, clear fetchValid, and start the pixel counter at 0.
- Each cell emits 8 glyph pixels (bit 7 first), then CELL_GAP zero pixels.
- Total band length is NUM_CELLS*(8+CELL_GAP) cycles, then outPixelValid drops.
- inCellStart with fetchValid=0 and outBusy=0: emit an all-zero band (valid high).
- inCellStart while outBusy: pulse outOverrun, emit an all-zero band; the fetch continues undisturbed.
- inCellStart during emission restarts emission at pixel 0 with a fresh swap under the same rules.
- inLineStart and inCellStart in the same cycle: the swap takes the old fetch buffer, then the new fetch starts. Both proceed.

## Timing
- Fetch latency: inLineStart at cycle t → first address at t+1, last address at t+NUM_CELLS, fetchValid at t+NUM_CELLS+2.
- outBusy is high for cycles t+1..t+NUM_CELLS+1.
- Emission: inCellStart at cycle t → first pixel at t+1, registered.
- Reset values: all outputs 0, FSM IDLE, both buffers zero, fetchValid=0.
- Reset mid-fetch or mid-emission aborts immediately. No partial buffer survives.

## Configuration
- DIGIT_SEQ_INVERT_EN defined: adds input inInvert[NUM_CELLS-1:0], sampled with inLineStart and carried with the buffer through the swap. Glyph pixels of a cell with its invert bit set are emitted inverted. Gap pixels and all-zero overrun bands are never inverted.
- Undefined: no inInvert port; glyph pixels are emitted as stored.

## Test plan
- Reset, then inCodes=8'b11_10_01_00, row 0, NUM_CELLS=4 → romAddress 0x00,0x10,0x20,0x30 on consecutive cycles; after inCellStart the pixel stream is 0x0C,0x3C,0x3C,0x17 MSB-first (32 valid cycles).
- Row 2, codes all 0, CELL_GAP=2 → each cell emits 11111100 then 00; 40 valid cycles; the last-cell byte equals 0xFC.
- inCellStart issued 2 cycles after inLineStart → outOverrun for 1 cycle, 32 zero pixels. The following band (no new fetch) shows the completed fetch data.
- inRowEnable=0 then inCellStart → no ROM addresses issued, 32 zero pixels with outPixelValid=1.
- Assert reset in the 3rd FETCH cycle → all outputs 0 next cycle; a subsequent inCellStart emits zeros.
- DIGIT_SEQ_INVERT_EN with inInvert=4'b0001 on row 0 → cell 0 emits 11110011, other cells unchanged, gap pixels 0.
